mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multicycle control unit that sequences fetch/decode/execute/memory/writeback for the 16-bit multicycle processor. It drives the datapath control strobes, including the pc_write and pc_write_cond inputs and the enable of the PC-update OR gate (or2to1) that forms the final PC load. It sits between the instruction register opcode field and the datapath. It waits on a memory ready handshake for every memory access.

Parameters:
OPC_W, 4, opcode field width
STATE_W, 4, state register width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
opcode  input  OPC_W  IR[15:12], valid from DECODE onward
mem_ready  input  1  memory completes the access this cycle
ir_write  output  1  load IR
pc_write  output  1  unconditional PC load (OR input 1)
pc_write_cond  output  1  branch PC load qualifier (ANDed with zero, OR input 2)
or_enable  output  1  enable for the PC-update OR gate
i_or_d  output  1  0=PC addresses memory, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register file write
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 1, 10=sign-ext imm, 11=shifted imm
alu_op  output  2  00=add, 01=sub, 10=funct, 11=pass
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
halted  output  1  processor stopped
illegal_op  output  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset: asynchronous, reset_n low forces state=RESET. All outputs 0 while in RESET. First rising edge with reset_n high moves to FETCH.
- Outputs are Moore-decoded from the state register, except ir_write/pc_write in FETCH, which are gated by mem_ready.
- Outputs not listed for a state are 0.
- or_enable = 1 in every state except RESET and HALT.
- Opcodes: 0000 R-type, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 JMP, 1111 HALT; all others are illegal.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - mem_ready=0: stay in FETCH; ir_write=0, pc_write=0.
  - mem_ready=1: ir_write=1, pc_write=1 in that same cycle; next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target).
  - Next: R-type->EXEC_R; ADDI, LW, SW->MEM_ADDR; BEQ->BRANCH; JMP->JUMP; HALT->HALT.
  - Illegal: illegal_op=1 for this cycle, next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: LW->MEM_RD, SW->MEM_WR, ADDI->ALU_WB_I.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready=1, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB_R.
- ALU_WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- ALU_WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- HALT: halted=1, all strobes 0. Terminal; exit only by reset.
- Latency with zero-wait memory:
  - BEQ, JMP: 3 cycles.
  - R-type, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- Invariants:
  - mem_read and mem_write are never both 1.
  - pc_write and pc_write_cond are never both 1.
- mem_ready is ignored in states that make no memory request.
- opcode is sampled only in DECODE and MEM_ADDR. IR is stable from DECODE until the next FETCH completes.
- Reset mid-access (e.g. in MEM_RD) drops mem_read immediately and asynchronously; no writeback occurs.
- Undefined state encodings recover to FETCH on the next edge.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants OPC_RTYPE, OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ, OPC_JMP, OPC_HALT.
  - state encodings S_RESET .. S_HALT.
  - ALU_OP and PC_SRC constants.
- One natural sub-module, mc_ctrl_decode: purely combinational state->output decode. The FSM keeps the state register and next-state logic.

Test Plan:
- Reset held low 3 cycles with opcode=0010 -> all outputs 0, state RESET; release -> FETCH with mem_read=1 on next cycle.
- R-type (0000), mem_ready tied 1 -> FETCH, DECODE, EXEC_R, ALU_WB_R over 4 cycles; reg_write=1, reg_dst=1 only in cycle 4; back in FETCH cycle 5.
- LW (0010), mem_ready low 2 cycles in MEM_RD -> 7 cycles total; mem_read,i_or_d=1 held 3 cycles; reg_write,mem_to_reg=1 once.
- BEQ (0100) -> pc_write_cond=1, pc_source=01, alu_op=01 in cycle 3 only; pc_write=0 there; or_enable=1.
- Opcode 1010 -> illegal_op pulse in DECODE cycle, next FETCH; opcode 1111 -> halted=1 and or_enable=0 indefinitely until reset_n low.
- Assert reset_n low mid-MEM_WR -> mem_write drops before next clock edge; restart at FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: field widths, opcode
// constants, state encodings, ALU/PC-source selects and the bundled strobe
// record produced by the output decoder.
package mc_pkg;

  localparam int OPC_W   = 4;
  localparam int STATE_W = 4;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 4'b0001;
  localparam logic [OPC_W-1:0] OPC_LW    = 4'b0010;
  localparam logic [OPC_W-1:0] OPC_SW    = 4'b0011;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 4'b0100;
  localparam logic [OPC_W-1:0] OPC_JMP   = 4'b0101;
  localparam logic [OPC_W-1:0] OPC_HALT  = 4'b1111;

  typedef enum logic [STATE_W-1:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_ALU_WB_R = 4'd8,
    S_ALU_WB_I = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } mc_state_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_PASS  = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_ONE   = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_SHIMM = 2'b11;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       or_enable;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic       illegal_op;
  } mc_ctrl_t;

  function automatic logic opc_is_legal(input logic [OPC_W-1:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_ADDI) || (opc == OPC_LW) ||
           (opc == OPC_SW)    || (opc == OPC_BEQ)  || (opc == OPC_JMP) ||
           (opc == OPC_HALT);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control/datapath boundary of the multicycle processor.
//   opcode, mem_ready : datapath -> controller
//   all strobes       : controller -> datapath
// Modport master is the controller side, slave is the datapath side.
interface mc_control_fsm_if;
  import mc_pkg::*;

  logic [OPC_W-1:0] opcode;
  logic             mem_ready;
  logic             ir_write;
  logic             pc_write;
  logic             pc_write_cond;
  logic             or_enable;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             halted;
  logic             illegal_op;

  modport master (
    input  opcode, mem_ready,
    output ir_write, pc_write, pc_write_cond, or_enable, i_or_d, mem_read,
           mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, pc_source, halted, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  ir_write, pc_write, pc_write_cond, or_enable, i_or_d, mem_read,
           mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, pc_source, halted, illegal_op
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control strobe decode.
//   state     : current controller state
//   opcode    : IR opcode field (only used for the illegal-opcode pulse)
//   mem_ready : gates the IR/PC load at the end of a fetch
//   ctrl      : bundled datapath strobes
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  mc_state_e        state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output mc_ctrl_t         ctrl
);

  always_comb begin
    ctrl = '0;
    // The PC-update OR gate stays live everywhere except while held in reset
    // or stopped; unknown encodings also leave it off until recovery.
    ctrl.or_enable = (state != S_RESET) && (state != S_HALT) &&
                     (state <= S_HALT);
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_ONE;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        // IR and PC+1 are captured only in the cycle memory delivers the word.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRC_B_SHIMM;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.illegal_op = !opc_is_legal(opcode);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_ALU_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ALU_WB_I: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath strobes through the bus interface.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : controller side of the control/datapath interface
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   S_RESET    | held in reset, all strobes low
//   S_FETCH    | read instruction at PC, load IR and PC+1 on ready
//   S_DECODE   | dispatch on opcode, precompute branch target
//   S_MEM_ADDR | effective address (LW/SW) or ADDI result
//   S_MEM_RD   | data read at ALUOut, wait for ready
//   S_MEM_WB   | MDR -> rt
//   S_MEM_WR   | data write at ALUOut, wait for ready
//   S_EXEC_R   | R-type ALU operation
//   S_ALU_WB_R | ALUOut -> rd
//   S_ALU_WB_I | ALUOut -> rt
//   S_BRANCH   | compare, conditional PC load from ALUOut
//   S_JUMP     | PC load from jump target
//   S_HALT     | stopped, left only by reset
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  mc_control_fsm_if.master  bus
);

  mc_state_e state_q;
  mc_state_e state_d;
  mc_ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OPC_RTYPE:                  state_d = S_EXEC_R;
          OPC_ADDI, OPC_LW, OPC_SW:   state_d = S_MEM_ADDR;
          OPC_BEQ:                    state_d = S_BRANCH;
          OPC_JMP:                    state_d = S_JUMP;
          OPC_HALT:                   state_d = S_HALT;
          default:                    state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        case (bus.opcode)
          OPC_LW:   state_d = S_MEM_RD;
          OPC_SW:   state_d = S_MEM_WR;
          OPC_ADDI: state_d = S_ALU_WB_I;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALU_WB_R;
      S_ALU_WB_R: state_d = S_FETCH;
      S_ALU_WB_I: state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.ir_write      = ctrl.ir_write;
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.or_enable     = ctrl.or_enable;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.halted        = ctrl.halted;
  assign bus.illegal_op    = ctrl.illegal_op;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  typedef enum int {
    T_RST, T_FETCH, T_DEC, T_MADDR, T_MRD, T_MWB, T_MWR,
    T_EXR, T_WBR, T_WBI, T_BR, T_JMP, T_HALT
  } tstate_e;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       or_enable;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    logic       rst_n;
    logic [3:0] opc;
    logic       rdy;
    tstate_e    st;
  } vec_t;

  logic clk;
  logic reset_n;
  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_vec;
  int    n_err;
  outs_t sb_q[$];
  vec_t  vecs[$];

  // Expected strobes for a state, written straight from the state table.
  function automatic outs_t model(input tstate_e st, input logic rdy,
                                  input logic [3:0] opc);
    outs_t e;
    e = '0;
    e.or_enable = (st != T_RST) && (st != T_HALT);
    case (st)
      T_FETCH: begin
        e.mem_read = 1; e.alu_src_b = 2'b01;
        e.ir_write = rdy; e.pc_write = rdy;
      end
      T_DEC: begin
        e.alu_src_b = 2'b11;
        e.illegal_op = !(opc inside {4'b0000, 4'b0001, 4'b0010, 4'b0011,
                                     4'b0100, 4'b0101, 4'b1111});
      end
      T_MADDR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      T_MRD:   begin e.mem_read = 1; e.i_or_d = 1; end
      T_MWB:   begin e.reg_write = 1; e.mem_to_reg = 1; end
      T_MWR:   begin e.mem_write = 1; e.i_or_d = 1; end
      T_EXR:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      T_WBR:   begin e.reg_write = 1; e.reg_dst = 1; end
      T_WBI:   begin e.reg_write = 1; end
      T_BR: begin
        e.alu_src_a = 1; e.alu_op = 2'b01;
        e.pc_write_cond = 1; e.pc_source = 2'b01;
      end
      T_JMP:   begin e.pc_write = 1; e.pc_source = 2'b10; end
      T_HALT:  begin e.halted = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic outs_t sample_dut();
    outs_t a;
    a.ir_write      = bus.ir_write;
    a.pc_write      = bus.pc_write;
    a.pc_write_cond = bus.pc_write_cond;
    a.or_enable     = bus.or_enable;
    a.i_or_d        = bus.i_or_d;
    a.mem_read      = bus.mem_read;
    a.mem_write     = bus.mem_write;
    a.reg_write     = bus.reg_write;
    a.reg_dst       = bus.reg_dst;
    a.mem_to_reg    = bus.mem_to_reg;
    a.alu_src_a     = bus.alu_src_a;
    a.alu_src_b     = bus.alu_src_b;
    a.alu_op        = bus.alu_op;
    a.pc_source     = bus.pc_source;
    a.halted        = bus.halted;
    a.illegal_op    = bus.illegal_op;
    return a;
  endfunction

  task automatic add(input logic r, input logic [3:0] o, input logic y,
                     input tstate_e s);
    vec_t v;
    v.rst_n = r; v.opc = o; v.rdy = y; v.st = s;
    vecs.push_back(v);
  endtask

  // Drive at the falling edge, check 1 ns later, well before the next rise.
  task automatic step(input string tag, input logic r, input logic [3:0] o,
                      input logic y, input tstate_e s);
    outs_t act, exp;
    @(negedge clk);
    reset_n        = r;
    bus.opcode     = o;
    bus.mem_ready  = y;
    sb_q.push_back(model(s, y, o));
    #1;
    act = sample_dut();
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s scoreboard empty got=%h", tag, act);
    end else begin
      exp = sb_q.pop_front();
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s (%s) got=%h expected=%h", tag, s.name(), act, exp);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus.opcode = 4'b0010;
    bus.mem_ready = 1'b0;

    // Reset held low, then released.
    add(0, 4'b0010, 1, T_RST);
    add(0, 4'b0010, 0, T_RST);
    add(0, 4'b0010, 1, T_RST);
    add(1, 4'b0010, 1, T_RST);
    // R-type, zero-wait.
    add(1, 4'b0000, 1, T_FETCH);
    add(1, 4'b0000, 0, T_DEC);
    add(1, 4'b0000, 1, T_EXR);
    add(1, 4'b0000, 0, T_WBR);
    // LW with two wait cycles in MEM_RD.
    add(1, 4'b0010, 1, T_FETCH);
    add(1, 4'b0010, 1, T_DEC);
    add(1, 4'b0010, 1, T_MADDR);
    add(1, 4'b0010, 0, T_MRD);
    add(1, 4'b0010, 0, T_MRD);
    add(1, 4'b0010, 1, T_MRD);
    add(1, 4'b0010, 0, T_MWB);
    // ADDI.
    add(1, 4'b0001, 1, T_FETCH);
    add(1, 4'b0001, 1, T_DEC);
    add(1, 4'b0001, 0, T_MADDR);
    add(1, 4'b0001, 1, T_WBI);
    // SW with a fetch wait and a write wait.
    add(1, 4'b0011, 0, T_FETCH);
    add(1, 4'b0011, 1, T_FETCH);
    add(1, 4'b0011, 1, T_DEC);
    add(1, 4'b0011, 1, T_MADDR);
    add(1, 4'b0011, 0, T_MWR);
    add(1, 4'b0011, 1, T_MWR);
    // BEQ.
    add(1, 4'b0100, 1, T_FETCH);
    add(1, 4'b0100, 1, T_DEC);
    add(1, 4'b0100, 1, T_BR);
    // JMP.
    add(1, 4'b0101, 1, T_FETCH);
    add(1, 4'b0101, 0, T_DEC);
    add(1, 4'b0101, 1, T_JMP);
    // Illegal opcode pulses once and returns to FETCH.
    add(1, 4'b1010, 1, T_FETCH);
    add(1, 4'b1010, 1, T_DEC);
    add(1, 4'b1010, 1, T_FETCH);
    add(1, 4'b0110, 1, T_DEC);
    add(1, 4'b0000, 1, T_FETCH);
    // HALT.
    add(1, 4'b1111, 1, T_DEC);
    add(1, 4'b1111, 1, T_HALT);
    add(1, 4'b0000, 0, T_HALT);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].opc, vecs[i].rdy,
           vecs[i].st);

    // HALT is terminal regardless of opcode/mem_ready.
    for (int i = 0; i < 12; i++)
      step($sformatf("halt_hold%0d", i), 1'b1, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), T_HALT);

    // Leave HALT through reset.
    step("halt_rst", 1'b0, 4'b0011, 1'b1, T_RST);
    step("halt_rel", 1'b1, 4'b0011, 1'b1, T_RST);

    // Reset mid MEM_WR: the write strobe must fall at the reset edge itself.
    step("wr_fetch", 1'b1, 4'b0011, 1'b1, T_FETCH);
    step("wr_dec",   1'b1, 4'b0011, 1'b1, T_DEC);
    step("wr_addr",  1'b1, 4'b0011, 1'b1, T_MADDR);
    step("wr_wait",  1'b1, 4'b0011, 1'b0, T_MWR);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.mem_write !== 1'b0 || bus.i_or_d !== 1'b0) begin
      n_err++;
      $display("FAIL wr_async_drop got mem_write=%b i_or_d=%b expected 0 0",
               bus.mem_write, bus.i_or_d);
    end
    step("wr_rst",   1'b0, 4'b0011, 1'b1, T_RST);
    step("wr_rel",   1'b1, 4'b0011, 1'b1, T_RST);
    step("wr_again", 1'b1, 4'b0011, 1'b1, T_FETCH);

    // Reset mid MEM_RD: no writeback follows.
    step("rd_dec",   1'b1, 4'b0010, 1'b1, T_DEC);
    step("rd_addr",  1'b1, 4'b0010, 1'b1, T_MADDR);
    step("rd_wait",  1'b1, 4'b0010, 1'b0, T_MRD);
    step("rd_rst",   1'b0, 4'b0010, 1'b1, T_RST);
    step("rd_rel",   1'b1, 4'b0010, 1'b1, T_RST);
    step("rd_fetch", 1'b1, 4'b0010, 1'b0, T_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
